// File: rtl/aes_pkg.sv
// Shared AES constants: block/byte widths, the inverse S-box table, the
// iterative-stage FSM encoding and a byte-position helper.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int POS_W       = $clog2(AES_BLOCK_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte 0 is the most significant byte of the 128-bit word.
    function automatic logic [POS_W-1:0] byte_lsb(input int idx);
        return POS_W'(AES_BLOCK_W - AES_BYTE_W * (idx + 1));
    endfunction

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box: one byte in, one substituted byte out.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] in,
    output logic [AES_BYTE_W-1:0] out
);

    assign out = INV_SBOX[in];

endmodule

// File: rtl/aes_inv_subbytes_iter.sv
// Iterative InvSubBytes: a captured block is substituted BYTES_PER_CYCLE bytes
// per cycle through shared inverse S-boxes, then held until downstream takes it.
module aes_inv_subbytes_iter
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   busy
);

    localparam int NCHUNK = 16 / BYTES_PER_CYCLE;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [AES_BLOCK_W-1:0] data_q, data_d;

    logic [AES_BYTE_W-1:0] sb_in  [BYTES_PER_CYCLE];
    logic [AES_BYTE_W-1:0] sb_out [BYTES_PER_CYCLE];

    // S-box j always serves byte cnt*B + j of the current chunk.
    always_comb begin
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            sb_in[j] = data_q[byte_lsb(int'(cnt_q) * BYTES_PER_CYCLE + j) +: AES_BYTE_W];
        end
    end

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .in  (sb_in[g]),
            .out (sb_out[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Handshakes: a transfer happens on an edge where valid and ready are both high;
    // in_ready and out_valid depend only on state, never combinationally on the peer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
                    data_d[byte_lsb(int'(cnt_q) * BYTES_PER_CYCLE + j) +: AES_BYTE_W] = sb_out[j];
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_aes_inv_subbytes_iter.sv
// Bench for aes_inv_subbytes_iter: directed scenarios plus random blocks, checked
// against an inverse S-box derived from GF(2^8) arithmetic and the AES affine map.
module tb_aes_inv_subbytes_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_data;
    logic         out_ready;

    logic         in_ready, out_valid, busy;
    logic [127:0] out_data;
    logic         in_ready_1, out_valid_1, busy_1;
    logic [127:0] out_data_1;
    logic         in_ready_16, out_valid_16, busy_16;
    logic [127:0] out_data_16;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0]   inv_tbl [256];
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;

    aes_inv_subbytes_iter #(.BYTES_PER_CYCLE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    aes_inv_subbytes_iter #(.BYTES_PER_CYCLE(1)) dut_b1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_1), .in_data(in_data),
        .out_valid(out_valid_1), .out_ready(out_ready), .out_data(out_data_1), .busy(busy_1)
    );

    aes_inv_subbytes_iter #(.BYTES_PER_CYCLE(16)) dut_b16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_16), .in_data(in_data),
        .out_valid(out_valid_16), .out_ready(out_ready), .out_data(out_data_16), .busy(busy_16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    function automatic logic [127:0] ref_inv(input logic [127:0] blk);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r   = {r[119:0], inv_tbl[blk[127:120]]};
            blk = blk << 8;
        end
        return r;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) check("accept_timeout", 1'b0, 1'b1);
    endtask

    // One block through the main instance, bp cycles of backpressure once it completes.
    task automatic send_block(input logic [127:0] blk, input int bp, output logic [127:0] got);
        int           lat;
        logic [127:0] held;
        wait_ready();
        in_data   = blk;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        exp_q.push_back(ref_inv(blk));
        tick();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        check("busy_after_accept", busy, 1'b1);
        lat = 0;
        do begin
            if (lat > 0 && lat < 4) in_valid = 1'b1;
            tick();
            lat++;
        end while (!out_valid && lat < 100);
        in_valid = 1'b0;
        check("latency", lat, 4);
        check("in_ready_done", in_ready, 1'b0);
        held = out_data;
        for (int k = 0; k < bp; k++) begin
            in_valid = 1'b1;
            tick();
            check("bp_valid", out_valid, 1'b1);
            check("bp_data", out_data, held);
            check("bp_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        got = out_data;
        if (exp_q.size() == 0) check("queue_underflow", 1'b0, 1'b1);
        else check("data", out_data, exp_q.pop_front());
        tick();
        out_ready = 1'b0;
        check("popped_valid", out_valid, 1'b0);
        check("popped_ready", in_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   x, inv, s;
        logic [127:0] blk, blk_b, got;
        logic [127:0] res_a, res_b, res_c;
        int           lat_a, lat_b, lat_c, n, nv;

        for (int xi = 0; xi < 256; xi++) begin
            x   = 8'(xi);
            inv = 8'h00;
            for (int yi = 1; yi < 256; yi++) begin
                if (gmul(x, 8'(yi)) == 8'h01) inv = 8'(yi);
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            inv_tbl[s] = x;
        end

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_data", out_data, 128'h0);
        rst_n = 1'b1;
        tick();

        // Known vector through all three widths, measuring latency of each.
        in_data   = 128'h000102030405060708090a0b0c0d0e0f;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check("s1_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        lat_a = 0; lat_b = 0; lat_c = 0;
        res_a = '0; res_b = '0; res_c = '0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (out_valid && lat_a == 0)    begin lat_a = k; res_a = out_data;    end
            if (out_valid_1 && lat_b == 0)  begin lat_b = k; res_b = out_data_1;  end
            if (out_valid_16 && lat_c == 0) begin lat_c = k; res_c = out_data_16; end
        end
        check("s1_lat_b4", lat_a, 4);
        check("s1_lat_b1", lat_b, 16);
        check("s1_lat_b16", lat_c, 1);
        check("s1_data_b4", res_a, 128'h52096ad53036a538bf40a39e81f3d7fb);
        check("s1_data_b1", res_b, 128'h52096ad53036a538bf40a39e81f3d7fb);
        check("s1_data_b16", res_c, 128'h52096ad53036a538bf40a39e81f3d7fb);
        check("s1_model", res_a, ref_inv(128'h000102030405060708090a0b0c0d0e0f));
        out_ready = 1'b0;

        send_block({16{8'h63}}, 0, got);
        check("s2_63", got, {16{8'h00}});
        send_block({16{8'h16}}, 1, got);
        check("s2_16", got, {16{8'hff}});
        send_block({16{8'h7c}}, 0, got);
        check("s2_7c", got, {16{8'h01}});

        send_block({$urandom, $urandom, $urandom, $urandom}, 5, got);

        // Second block held valid through RUN/DONE must wait for the first IDLE cycle.
        wait_ready();
        blk   = {$urandom, $urandom, $urandom, $urandom};
        blk_b = {$urandom, $urandom, $urandom, $urandom};
        in_data   = blk;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back(ref_inv(blk));
        tick();
        in_data = blk_b;
        check("s4_busy", busy, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        check("s4_first_valid", out_valid, 1'b1);
        check("s4_first_data", out_data, exp_q.pop_front());
        tick();
        check("s4_no_capture_on_pop", busy, 1'b0);
        check("s4_ready_after_pop", in_ready, 1'b1);
        exp_q.push_back(ref_inv(blk_b));
        tick();
        in_valid = 1'b0;
        check("s4_second_busy", busy, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        check("s4_second_data", out_data, exp_q.pop_front());
        tick();
        out_ready = 1'b0;

        // Reset at cnt==2 with in_valid asserted: nothing survives, nothing is captured.
        wait_ready();
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("s5_mid_run", busy, 1'b1);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        check("s5_in_ready", in_ready, 1'b1);
        check("s5_out_valid", out_valid, 1'b0);
        check("s5_busy", busy, 1'b0);
        check("s5_data", out_data, 128'h0);
        nv = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            nv += int'(out_valid);
        end
        out_ready = 1'b0;
        check("s5_no_pulse", nv, 0);
        send_block({$urandom, $urandom, $urandom, $urandom}, 0, got);

        for (int t = 0; t < 20; t++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_block({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3), got);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
